// File: rtl/seven_segment_frame_display.sv
// seven_segment_frame_display
//   Captures received frames into a circular history buffer and renders either
//   the channel number or a selected history frame (binary, hex or decimal) on
//   NUM_DIGITS nibble digits for the 7-segment scan multiplexer.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   frame_valid  - one-cycle strobe, frame captured when high
//   frame        - received frame value
//   channel      - current channel number
//   mode         - 0 channel, 1 binary, 2 hex, 3 decimal
//   hist_sel     - history entry to show, 0 = newest
//   digit        - digit nibbles, digit 0 least significant (4'hF when blank)
//   blank        - per-digit blank flag
//   en_dot       - per-digit decimal point (top = overflow, bit 0 = stale entry)
//   conv_busy    - decimal conversion in progress
module seven_segment_frame_display #(
  parameter int NUM_DIGITS = 8,
  parameter int FRAME_W    = 9,
  parameter int CH_W       = 2,
  parameter int HIST_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_valid,
  input  logic [FRAME_W-1:0]            frame,
  input  logic [CH_W-1:0]               channel,
  input  logic [1:0]                    mode,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_sel,
  output logic [NUM_DIGITS*4-1:0]       digit,
  output logic [NUM_DIGITS-1:0]         blank,
  output logic [NUM_DIGITS-1:0]         en_dot,
  output logic                          conv_busy
);

  localparam int SEL_W  = $clog2(HIST_DEPTH);
  localparam int CNT_W  = $clog2(HIST_DEPTH + 1);
  localparam int DW     = 4 * NUM_DIGITS;
  localparam int EXT_W  = (FRAME_W > DW) ? FRAME_W : DW;
  localparam int ITER_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  FULL = CNT_W'(HIST_DEPTH);
  localparam logic [ITER_W-1:0] LAST = ITER_W'(FRAME_W);

  typedef enum logic [1:0] {MODE_CHAN, MODE_BIN, MODE_HEX, MODE_DEC} mode_e;
  typedef enum logic {CONV_IDLE, CONV_RUN} conv_state_e;

  // History buffer
  logic [FRAME_W-1:0] hist_mem [HIST_DEPTH];
  logic [SEL_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   vcount, vcount_nxt;
  logic [SEL_W-1:0]   rd_idx;
  logic [FRAME_W-1:0] sel_val;
  logic               sel_ok;
  logic               stale;

  // Registered outputs / converter state
  conv_state_e         state_q, state_nxt;
  logic [DW-1:0]       digit_nxt;
  logic [NUM_DIGITS-1:0] blank_nxt, en_dot_nxt;
  logic                busy_nxt;
  logic [FRAME_W-1:0]  bin_q, bin_nxt;
  logic [DW-1:0]       bcd_q, bcd_nxt;
  logic [ITER_W-1:0]   iter_q, iter_nxt;
  logic                ovf_q, ovf_nxt;
  logic                stale_q, stale_nxt;
  logic [1:0]          prev_mode;
  logic [SEL_W-1:0]    prev_sel;

  mode_e cur_mode;
  assign cur_mode = mode_e'(mode);

  // Leading-zero mask: digits above the most significant non-zero one are
  // blanked; digit 0 is never blanked.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DW-1:0] d);
    logic seen;
    lz_mask = '0;
    seen = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      if (d[4*(NUM_DIGITS-1-k) +: 4] != 4'h0) seen = 1'b1;
      lz_mask[NUM_DIGITS-1-k] = !seen;
    end
  endfunction

  function automatic logic [DW-1:0] apply_blank(input logic [DW-1:0] d,
                                                input logic [NUM_DIGITS-1:0] m);
    apply_blank = d;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (m[i]) apply_blank[4*i +: 4] = 4'hF;
  endfunction

  // Selected entry with same-edge bypass: when a frame is being written, the
  // history is viewed as if the write had already happened.
  always_comb begin
    vcount_nxt = (frame_valid && vcount != FULL) ? vcount + CNT_W'(1) : vcount;
    rd_idx     = frame_valid ? wr_ptr - hist_sel : wr_ptr - SEL_W'(1) - hist_sel;
    sel_val    = (frame_valid && hist_sel == '0) ? frame : hist_mem[rd_idx];
    sel_ok     = CNT_W'(hist_sel) < vcount_nxt;
    stale      = hist_sel != '0;
  end

  // Binary and hex renderings
  logic [EXT_W-1:0]      val_ext;
  logic [DW-1:0]         hex_d, bin_d;
  logic [NUM_DIGITS-1:0] hex_blank, bin_blank;
  logic                  hex_ovf, bin_ovf;

  always_comb begin
    val_ext   = EXT_W'(sel_val);
    hex_d     = val_ext[DW-1:0];
    hex_blank = lz_mask(hex_d);
    hex_ovf   = 1'b0;
    for (int unsigned b = DW; b < EXT_W; b++) hex_ovf = hex_ovf | val_ext[b];
    bin_d     = '0;
    bin_blank = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      bin_d[4*i +: 4] = {3'b000, val_ext[i]};
      bin_blank[i]    = (i >= FRAME_W);
    end
    bin_ovf = 1'b0;
    for (int unsigned b = NUM_DIGITS; b < EXT_W; b++) bin_ovf = bin_ovf | val_ext[b];
  end

  // One double-dabble iteration; a carry out of the top BCD digit means the
  // value has more decimal digits than the display.
  logic [DW-1:0]      bcd_adj, bcd_step;
  logic [FRAME_W-1:0] bin_step;
  logic               step_carry;

  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    step_carry = bcd_adj[DW-1];
    bcd_step   = {bcd_adj[DW-2:0], bin_q[FRAME_W-1]};
    bin_step   = bin_q << 1;
  end

  logic trigger;
  assign trigger = (cur_mode == MODE_DEC) &&
                   (prev_mode != MODE_DEC || frame_valid || hist_sel != prev_sel);

  // Next-state and output logic
  always_comb begin
    state_nxt  = state_q;
    digit_nxt  = digit;
    blank_nxt  = blank;
    en_dot_nxt = en_dot;
    busy_nxt   = conv_busy;
    bin_nxt    = bin_q;
    bcd_nxt    = bcd_q;
    iter_nxt   = iter_q;
    ovf_nxt    = ovf_q;
    stale_nxt  = stale_q;

    if (cur_mode != MODE_DEC) begin
      state_nxt  = CONV_IDLE;
      busy_nxt   = 1'b0;
      digit_nxt  = '1;
      blank_nxt  = '1;
      en_dot_nxt = '0;
      if (cur_mode == MODE_CHAN) begin
        digit_nxt[3:0] = 4'(channel);
        blank_nxt[0]   = 1'b0;
      end else if (sel_ok) begin
        if (cur_mode == MODE_BIN) begin
          blank_nxt = bin_blank;
          digit_nxt = apply_blank(bin_d, bin_blank);
          en_dot_nxt[NUM_DIGITS-1] = bin_ovf;
        end else begin
          blank_nxt = hex_blank;
          digit_nxt = apply_blank(hex_d, hex_blank);
          en_dot_nxt[NUM_DIGITS-1] = hex_ovf;
        end
        en_dot_nxt[0] = stale;
      end
    end else if (!sel_ok) begin
      state_nxt  = CONV_IDLE;
      busy_nxt   = 1'b0;
      digit_nxt  = '1;
      blank_nxt  = '1;
      en_dot_nxt = '0;
    end else if (trigger) begin
      // Restart keeps conv_busy as it was; displayed digits hold.
      state_nxt = CONV_RUN;
      bin_nxt   = sel_val;
      bcd_nxt   = '0;
      iter_nxt  = '0;
      ovf_nxt   = 1'b0;
      stale_nxt = stale;
    end else if (state_q == CONV_RUN) begin
      if (iter_q == LAST) begin
        state_nxt  = CONV_IDLE;
        busy_nxt   = 1'b0;
        blank_nxt  = lz_mask(bcd_q);
        digit_nxt  = apply_blank(bcd_q, lz_mask(bcd_q));
        en_dot_nxt = '0;
        en_dot_nxt[NUM_DIGITS-1] = ovf_q;
        en_dot_nxt[0]            = stale_q;
      end else begin
        busy_nxt = 1'b1;
        bcd_nxt  = bcd_step;
        bin_nxt  = bin_step;
        iter_nxt = iter_q + ITER_W'(1);
        ovf_nxt  = ovf_q | step_carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && frame_valid) hist_mem[wr_ptr] <= frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      vcount    <= '0;
      state_q   <= CONV_IDLE;
      digit     <= '1;
      blank     <= '1;
      en_dot    <= '0;
      conv_busy <= 1'b0;
      bin_q     <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
      ovf_q     <= 1'b0;
      stale_q   <= 1'b0;
      prev_mode <= MODE_CHAN;
      prev_sel  <= '0;
    end else begin
      if (frame_valid) wr_ptr <= wr_ptr + SEL_W'(1);
      vcount    <= vcount_nxt;
      state_q   <= state_nxt;
      digit     <= digit_nxt;
      blank     <= blank_nxt;
      en_dot    <= en_dot_nxt;
      conv_busy <= busy_nxt;
      bin_q     <= bin_nxt;
      bcd_q     <= bcd_nxt;
      iter_q    <= iter_nxt;
      ovf_q     <= ovf_nxt;
      stale_q   <= stale_nxt;
      prev_mode <= mode;
      prev_sel  <= hist_sel;
    end
  end

endmodule

// File: tb/tb_seven_segment_frame_display.sv
// Self-checking bench for seven_segment_frame_display: directed scenarios with
// literal expectations plus randomized traffic compared every cycle against a
// behavioural model (history queue, arithmetic digit extraction, cycle counter
// for the decimal conversion latency).
module tb_seven_segment_frame_display;
  localparam int ND = 8;
  localparam int FW = 9;
  localparam int CW = 2;
  localparam int HD = 4;
  localparam int SW = $clog2(HD);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fv = 1'b0;
  logic [FW-1:0] frame = '0;
  logic [CW-1:0] channel = '0;
  logic [1:0]    mode = 2'd0;
  logic [SW-1:0] hist_sel = '0;
  logic [4*ND-1:0] digit;
  logic [ND-1:0]   blank, en_dot;
  logic            conv_busy;

  seven_segment_frame_display #(
    .NUM_DIGITS(ND), .FRAME_W(FW), .CH_W(CW), .HIST_DEPTH(HD)
  ) dut (
    .clk(clk), .rst(rst), .frame_valid(fv), .frame(frame), .channel(channel),
    .mode(mode), .hist_sel(hist_sel), .digit(digit), .blank(blank),
    .en_dot(en_dot), .conv_busy(conv_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned hq[$];
  logic [31:0] m_digit;
  logic [7:0]  m_blank, m_dot;
  logic        m_busy;
  int          conv_cnt;
  int unsigned conv_val;
  logic        conv_stale;
  logic [1:0]  pmode;
  logic [SW-1:0] psel;
  bit          ready = 0;
  bit          m_ok;
  int unsigned m_val;

  task automatic render(input int unsigned v, input int unsigned radix, input bit st,
                        output logic [31:0] d, output logic [7:0] b, output logic [7:0] e);
    int unsigned n, t, p;
    n = 1; t = v / radix; p = 1;
    while (t > 0) begin n++; t = t / radix; end
    d = '1; b = '1; e = '0;
    for (int i = 0; i < ND; i++) begin
      if (i < n) begin
        d[4*i +: 4] = 4'((v / p) % radix);
        b[i] = 1'b0;
      end
      p = p * radix;
    end
    e[ND-1] = (n > ND);
    e[0] = st;
  endtask

  task automatic render_bin(input int unsigned v, input bit st,
                            output logic [31:0] d, output logic [7:0] b, output logic [7:0] e);
    d = '1; b = '1; e = '0;
    for (int i = 0; i < ND; i++)
      if (i < FW) begin
        d[4*i +: 4] = 4'((v >> i) & 1);
        b[i] = 1'b0;
      end
    e[ND-1] = (v >> ND) != 0;
    e[0] = st;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      hq.delete();
      m_digit = '1; m_blank = '1; m_dot = '0; m_busy = 0;
      conv_cnt = 0; pmode = 2'd0; psel = '0; ready = 1;
    end else begin
      if (fv) begin
        hq.push_front(int'(frame));
        if (hq.size() > HD) void'(hq.pop_back());
      end
      m_ok  = int'(hist_sel) < hq.size();
      m_val = m_ok ? hq[hist_sel] : 0;
      if (mode != 2'd3) begin
        m_busy = 0; conv_cnt = 0;
        m_digit = '1; m_blank = '1; m_dot = '0;
        if (mode == 2'd0) begin
          m_digit[3:0] = 4'(channel);
          m_blank = 8'hFE;
        end else if (m_ok) begin
          if (mode == 2'd1) render_bin(m_val, hist_sel != 0, m_digit, m_blank, m_dot);
          else render(m_val, 16, hist_sel != 0, m_digit, m_blank, m_dot);
        end
      end else if (!m_ok) begin
        m_busy = 0; conv_cnt = 0;
        m_digit = '1; m_blank = '1; m_dot = '0;
      end else if (pmode != 2'd3 || fv || hist_sel != psel) begin
        conv_cnt = FW + 1;
        conv_val = m_val;
        conv_stale = hist_sel != 0;
      end else if (conv_cnt > 0) begin
        conv_cnt--;
        if (conv_cnt == 0) begin
          render(conv_val, 10, conv_stale, m_digit, m_blank, m_dot);
          m_busy = 0;
        end else m_busy = 1;
      end
      pmode = mode;
      psel = hist_sel;
    end
  end

  always @(negedge clk) begin
    if (ready) begin
      chk("model_digit", digit, m_digit);
      chk("model_blank", 32'(blank), 32'(m_blank));
      chk("model_en_dot", 32'(en_dot), 32'(m_dot));
      chk("model_busy", 32'(conv_busy), 32'(m_busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic r, input logic v, input logic [FW-1:0] f,
                     input logic [1:0] m, input logic [SW-1:0] s, input logic [CW-1:0] c);
    rst = r; fv = v; frame = f; mode = m; hist_sel = s; channel = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    bit seen507;
    logic [1:0] rm;
    logic [SW-1:0] rs;

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("reset_digit", digit, 32'hFFFFFFFF);
    chk("reset_blank", 32'(blank), 32'hFF);
    chk("reset_dot", 32'(en_dot), 32'h0);
    chk("reset_busy", 32'(conv_busy), 32'h0);

    cyc(0, 0, 0, 2'd0, 0, 2'd3);
    chk("chan_digit", digit, 32'hFFFFFFF3);
    chk("chan_blank", 32'(blank), 32'hFE);
    chk("chan_dot", 32'(en_dot), 32'h0);

    // reset in the middle of a decimal conversion
    cyc(0, 1, 9'd507, 2'd3, 0, 0);
    repeat (3) cyc(0, 0, 0, 2'd3, 0, 0);
    chk("midconv_busy_before", 32'(conv_busy), 32'h1);
    cyc(1, 1, 9'd99, 2'd3, 0, 0);
    chk("midrst_digit", digit, 32'hFFFFFFFF);
    chk("midrst_blank", 32'(blank), 32'hFF);
    chk("midrst_busy", 32'(conv_busy), 32'h0);

    cyc(0, 1, 9'h1A5, 2'd2, 0, 0);
    chk("hex_digit", digit, 32'hFFFFF1A5);
    chk("hex_blank", 32'(blank), 32'hF8);
    chk("hex_dot", 32'(en_dot), 32'h0);
    cyc(0, 0, 0, 2'd1, 0, 0);
    chk("bin_digit", digit, 32'h10100101);
    chk("bin_blank", 32'(blank), 32'h00);
    chk("bin_dot", 32'(en_dot), 32'h80);

    // decimal 507: busy exactly FW cycles
    cyc(0, 1, 9'd507, 2'd3, 0, 0);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      cyc(0, 0, 0, 2'd3, 0, 0);
      if (conv_busy) n++;
      else if (n > 0) break;
    end
    chk("dec_busy_cycles", 32'(n), 32'd9);
    chk("dec_digit", digit, 32'hFFFFF507);
    chk("dec_blank", 32'(blank), 32'hF8);

    // restart: 42 arrives 4 cycles in, 507 must never appear
    cyc(0, 0, 0, 2'd0, 0, 0);
    cyc(0, 1, 9'd507, 2'd3, 0, 0);
    seen507 = 0;
    repeat (4) begin
      cyc(0, 0, 0, 2'd3, 0, 0);
      if (digit == 32'hFFFFF507) seen507 = 1;
    end
    cyc(0, 1, 9'd42, 2'd3, 0, 0);
    for (int k = 0; k < 30; k++) begin
      if (digit == 32'hFFFFF507) seen507 = 1;
      if (!conv_busy) break;
      cyc(0, 0, 0, 2'd3, 0, 0);
    end
    chk("restart_done", 32'(conv_busy), 32'h0);
    chk("restart_no507", 32'(seen507), 32'h0);
    chk("restart_digit", digit, 32'hFFFFFF42);
    chk("restart_blank", 32'(blank), 32'hFC);

    // history wrap
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) cyc(0, 1, FW'(10 * k), 2'd2, 0, 0);
    cyc(0, 0, 0, 2'd2, 2'd3, 0);
    chk("hist3_digit", digit, 32'hFFFFFF14);
    chk("hist3_blank", 32'(blank), 32'hFC);
    chk("hist3_dot", 32'(en_dot), 32'h01);
    cyc(0, 0, 0, 2'd2, 2'd0, 0);
    chk("hist0_digit", digit, 32'hFFFFFF32);
    chk("hist0_dot", 32'(en_dot), 32'h00);

    // invalid entry in decimal mode
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 9'd77, 2'd0, 0, 2'd1);
    repeat (5) begin
      cyc(0, 0, 0, 2'd3, 2'd2, 2'd1);
      chk("invalid_blank", 32'(blank), 32'hFF);
      chk("invalid_busy", 32'(conv_busy), 32'h0);
    end
    cyc(0, 0, 0, 2'd0, 2'd2, 2'd1);
    chk("back_to_chan", digit, 32'hFFFFFFF1);
    chk("back_to_chan_blank", 32'(blank), 32'hFE);

    // randomized traffic, model checked every cycle
    rm = 2'd3; rs = '0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 49) == 0) rm = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) rs = SW'($urandom_range(0, HD - 1));
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0),
          FW'($urandom), rm, rs, CW'($urandom));
    end
    cyc(0, 0, 0, 2'd0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
